// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: shared encodings and lane/alignment helpers for the load/store unit
package lsu_mem_ctrl_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {F_NONE, F_MISALIGN, F_TIMEOUT, F_ILLEGAL} fault_t;
  function automatic logic illegal_op(logic rd, logic wr, logic [2:0] f3);
    return (rd & wr) | (rd & !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) |
           (wr & !(f3 inside {F3_B, F3_H, F3_W}));
  endfunction
  function automatic logic misaligned(logic [2:0] f3, logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
  function automatic logic [3:0] byte_en(logic we, logic [2:0] f3, logic [1:0] off);
    return !we ? 4'hf :
           f3[1:0] == 2'b00 ? 4'b0001 << off :
           f3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'hf;
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: req/ack data-memory bus between the LSU and memory
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_mem_ctrl_load_align.sv
// lsu_mem_ctrl_load_align: picks the addressed byte/half from a read word and extends it
module lsu_mem_ctrl_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // funct3[2] selects zero extension, funct3[1:0] the access size
  always_comb begin
    b = rdata[8*off +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    data = funct3[1:0] == 2'b00 ? {{24{b[7] & !funct3[2]}}, b} :
           funct3[1:0] == 2'b01 ? {{16{h[15] & !funct3[2]}}, h} : rdata;
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: turns decoder load/store requests into req/ack memory transactions
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WData,
  output logic              Stall,
  output logic              Done,
  output logic [31:0]       RData,
  output logic [1:0]        FaultCause,
  lsu_mem_ctrl_if.master    mem
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t            state_q, state_d;
  fault_t            fault_q, fault_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, done_q, done_d, stall;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, ld_data;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  lsu_mem_ctrl_load_align u_align (.rdata(mem.mem_rdata), .off(off_q), .funct3(f3_q), .data(ld_data));
  // next-state, latching of the accepted request and completion/fault handling
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = MemRead | MemWrite;
        if (MemRead | MemWrite) begin
          if (illegal_op(MemRead, MemWrite, Funct3) || misaligned(Funct3, Addr[1:0])) begin
            state_d = DONE;
            fault_d = illegal_op(MemRead, MemWrite, Funct3) ? F_ILLEGAL : F_MISALIGN;
            rdata_d = MemRead ? 32'h0 : rdata_q;
          end else begin
            state_d = BUSY;
            fault_d = F_NONE;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {Addr[ADDR_W-1:2], 2'b00};
            be_d    = byte_en(MemWrite, Funct3, Addr[1:0]);
            wdata_d = Funct3[1:0] == 2'b00 ? {4{WData[7:0]}} :
                      Funct3[1:0] == 2'b01 ? {2{WData[15:0]}} : WData;
            f3_d    = Funct3;
            off_d   = Addr[1:0];
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = we_q ? rdata_q : ld_data;
        end else if (TIMEOUT > 0 && cnt_q == TLIM) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = 32'h0;
          fault_d = F_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE;
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fault_q <= F_NONE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end
  assign Stall         = rst_n & stall;
  assign Done          = done_q;
  assign RData         = rdata_q;
  assign FaultCause    = fault_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized transaction-level check of the load/store unit
module tb_lsu_mem_ctrl;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst_n, MemRead, MemWrite, Stall, Done;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WData, RData;
  logic [1:0]  FaultCause;
  logic [31:0] rdata_m;
  int n_cmp = 0;
  int n_bad = 0;
  lsu_mem_ctrl_if #(.ADDR_W(32)) mem_if ();
  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .Addr(Addr), .WData(WData), .Stall(Stall), .Done(Done), .RData(RData),
    .FaultCause(FaultCause), .mem(mem_if)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    int sz;
    logic [31:0] v, m;
    sz = 1 << f3[1:0];
    if (sz >= 4) return w;
    v = w >> (8 * off);
    m = (32'd1 << (8 * sz)) - 1;
    v = v & m;
    if (!f3[2] && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  // One complete access; dly = number of wait cycles before ack (dly >= TO never acks)
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input logic [31:0] word);
    bit ill, mis, tout;
    int sz, nbusy;
    logic [3:0] be_e;
    logic [31:0] wd_e;
    logic [1:0] fault_e;
    sz   = 1 << f3[1:0];
    ill  = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 > 2);
    mis  = !ill && (a % sz) != 0;
    tout = dly >= TO;
    for (int l = 0; l < 4; l++) be_e[l] = rd || (l >= a[1:0] && l < a[1:0] + sz);
    wd_e = f3[1:0] == 0 ? wd[7:0] * 32'h01010101 : f3[1:0] == 1 ? wd[15:0] * 32'h00010001 : wd;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WData = wd;
    #1;
    chk("stall_req", Stall, 1);
    if (ill || mis) begin
      fault_e = ill ? 2'b11 : 2'b01;
      if (rd) rdata_m = 0;
    end else begin
      fault_e = tout ? 2'b10 : 2'b00;
      nbusy = tout ? TO : dly + 1;
      for (int c = 0; c < nbusy; c++) begin
        @(negedge clk);
        #1;
        chk("busy_req", mem_if.mem_req, 1);
        chk("busy_stall", Stall, 1);
        chk("busy_done", Done, 0);
        if (c == 0) begin
          chk("mem_addr", mem_if.mem_addr, a & ~32'h3);
          chk("mem_we", mem_if.mem_we, wr);
          chk("mem_be", mem_if.mem_be, be_e);
          if (wr) chk("mem_wdata", mem_if.mem_wdata, wd_e);
        end
        if (!tout && c == dly) begin
          mem_if.mem_ack = 1; mem_if.mem_rdata = word;
        end
      end
      if (tout) rdata_m = 0;
      else if (rd) rdata_m = ext(word, a[1:0], f3);
    end
    @(negedge clk);
    mem_if.mem_ack = 0; mem_if.mem_rdata = $urandom;
    #1;
    chk("done", Done, 1);
    chk("done_stall", Stall, 0);
    chk("done_req", mem_if.mem_req, 0);
    chk("fault", FaultCause, fault_e);
    chk("rdata", RData, rdata_m);
    MemRead = 0; MemWrite = 0;
    @(negedge clk);
    #1;
    chk("done_pulse", Done, 0);
    chk("rdata_hold", RData, rdata_m);
  endtask

  task automatic idle_ack();
    @(negedge clk);
    mem_if.mem_ack = 1; mem_if.mem_rdata = $urandom;
    #1;
    chk("idle_stall", Stall, 0);
    @(negedge clk);
    mem_if.mem_ack = 0;
    #1;
    chk("idle_done", Done, 0);
    chk("idle_req", mem_if.mem_req, 0);
    chk("idle_rdata", RData, rdata_m);
  endtask

  initial begin
    bit rd, wr;
    int k;
    logic [2:0] f3;
    logic [31:0] a;
    rst_n = 0; MemRead = 1; MemWrite = 0; Funct3 = 0; Addr = 0; WData = 0;
    mem_if.mem_ack = 0; mem_if.mem_rdata = 0; rdata_m = 0;
    #3;
    chk("rst_stall", Stall, 0);
    chk("rst_req", mem_if.mem_req, 0);
    chk("rst_done", Done, 0);
    chk("rst_rdata", RData, 0);
    chk("rst_fault", FaultCause, 0);
    chk("rst_be", mem_if.mem_be, 0);
    chk("rst_addr", mem_if.mem_addr, 0);
    repeat (2) @(negedge clk);
    MemRead = 0; rst_n = 1;
    access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 1, 0);
    access(1, 0, 3'b000, 32'h203, 0, 0, 32'h80FF1234);
    chk("plan_lb", RData, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h203, 0, 0, 32'h80FF1234);
    chk("plan_lbu", RData, 32'h00000080);
    access(1, 0, 3'b101, 32'h202, 0, 0, 32'h80FF1234);
    chk("plan_lhu", RData, 32'h000080FF);
    access(0, 1, 3'b001, 32'h12, 32'h0000ABCD, 0, 0);
    access(1, 0, 3'b010, 32'h102, 0, 0, 0);
    chk("plan_mis_fault", FaultCause, 2'b01);
    access(1, 1, 3'b010, 32'h100, 0, 0, 0);
    chk("plan_ill_fault", FaultCause, 2'b11);
    access(1, 0, 3'b010, 32'h300, 0, TO, 0);
    chk("plan_tout_fault", FaultCause, 2'b10);
    idle_ack();
    @(negedge clk);
    MemRead = 1; Funct3 = 3'b010; Addr = 32'h40;
    @(negedge clk);
    #1;
    chk("mid_req", mem_if.mem_req, 1);
    rst_n = 0; MemRead = 0;
    #1;
    chk("mid_rst_req", mem_if.mem_req, 0);
    chk("mid_rst_stall", Stall, 0);
    chk("mid_rst_done", Done, 0);
    @(negedge clk);
    rst_n = 1; rdata_m = 0;
    @(negedge clk);
    #1;
    chk("post_rst_done", Done, 0);
    access(1, 0, 3'b010, 32'h20, 0, 2, 32'h11223344);
    chk("plan_lw_after_rst", RData, 32'h11223344);
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      rd = k < 5 || k == 9;
      wr = k >= 5;
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 > 2) f3 = f3 + 1;
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 1);
      access(rd, wr, f3, a, $urandom, $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 4) == 0) idle_ack();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit sitting between the datapath and data memory. It acts on the MemRead/MemWrite/Funct3 decisions made by the main decoder.
- Converts each request into a req/ack memory transaction with byte enables.
- Stalls the pipeline until the transaction completes.
- Returns aligned, sign/zero-extended load data.
- Reports faults: misalignment, timeout, illegal operation.

Parameters:
ADDR_W, 32, byte-address width on both sides.
TIMEOUT, 255, maximum BUSY cycles to wait for mem_ack; 0 disables the timeout.

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
MemRead  in  1  load request from decoder
MemWrite  in  1  store request from decoder
Funct3  in  3  access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010)
Addr  in  ADDR_W  byte address from ALU
WData  in  32  store data (rs2)
Stall  out  1  holds pipeline while an access is in flight
Done  out  1  one-cycle pulse; access finished (RData/FaultCause valid)
RData  out  32  extended load data, registered
FaultCause  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal; valid with Done
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address {Addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completion
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async): state IDLE; timeout counter 0. All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, RData, Done, FaultCause. Stall is forced 0 while rst_n is low.
- FSM states: IDLE, BUSY, DONE.
- IDLE: a request is MemRead|MemWrite. Stall = request (combinational).
  - Legal, aligned request: latch Funct3, Addr[1:0], mem_addr, mem_be, mem_wdata, mem_we. Set mem_req=1; go to BUSY.
  - MemRead&MemWrite both high, or Funct3 in {011,110,111} (loads) / {011..111} (stores): go to DONE with FaultCause=11; no mem_req.
  - Misaligned (H with Addr[0]=1, W with Addr[1:0]!=0): go to DONE with FaultCause=01; no mem_req.
- BUSY: Stall=1; mem_req held at 1 with all mem_* outputs stable.
  - mem_ack: drop mem_req; for loads register the extended data into RData; go to DONE.
  - Counter reaches TIMEOUT with no ack (TIMEOUT>0): drop mem_req; RData=0; FaultCause=10; go to DONE.
- DONE: Stall=0, Done=1 for exactly one cycle; inputs are ignored (the pipeline advances this cycle); go to IDLE.
- FaultCause is cleared to 00 when the next access is accepted. RData holds its value until the next load completes; a faulted load sets it to 0.
- Store lanes:
  - SB: be = 0001<<off; wdata = {4{WData[7:0]}}.
  - SH: be = off[1] ? 1100 : 0011; wdata = {2{WData[15:0]}}.
  - SW: be = 1111.
- Loads: mem_be=1111. The byte/half at off is selected from mem_rdata; LB/LH sign-extend, LBU/LHU zero-extend.
- Latency: an access with ack in its first BUSY cycle has Stall high for 2 cycles and Done on the 3rd. Each wait cycle adds 1.
- mem_ack outside BUSY is ignored.
- Reset mid-access aborts the transaction: mem_req falls immediately and no Done is generated.

Decomposition:
- lsu_pkg holds:
  - Funct3 localparams.
  - state_t enum {IDLE,BUSY,DONE}.
  - fault_t enum {F_NONE,F_MISALIGN,F_TIMEOUT,F_ILLEGAL}.
  - functions for byte-enable generation and the misalignment check.
- Sub-module lsu_load_align: combinational; (mem_rdata, off, funct3) -> extended 32-bit data.

Test Plan:
- SW, Addr=0x104, WData=0xDEADBEEF, ack on 2nd BUSY cycle -> mem_addr=0x104, be=1111, mem_we=1, mem_req high 2 cycles, Stall high 3 cycles, then Done with FaultCause=00.
- LB, Addr=0x203, mem_rdata=0x80FF1234, immediate ack -> RData=0xFFFFFF80. Repeat with LBU -> 0x00000080. Repeat with LHU at Addr=0x202 -> 0x000080FF.
- SH, Addr=0x12, WData=0x0000ABCD -> mem_addr=0x10, be=1100, mem_wdata=0xABCDABCD.
- LW, Addr=0x102 -> no mem_req; Done next cycle with FaultCause=01, RData=0. MemRead=MemWrite=1 -> FaultCause=11.
- TIMEOUT=4, load with no ack -> mem_req high 4 cycles then low; Done with FaultCause=10; a later ack pulse in IDLE is ignored.
- rst_n low during BUSY -> mem_req, Stall, Done go 0 immediately. After release, LW at Addr=0x20 with rdata 0x11223344 completes with RData=0x11223344.
